// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, default widths and slave ids for the bus master port.
package bus_pkg;
   typedef enum logic [3:0] {
      ST_IDLE, ST_SEL0, ST_SEL1, ST_WAIT, ST_BACKOFF,
      ST_ADDR, ST_WDATA, ST_ACKW, ST_RDATA, ST_DONE
   } state_t;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;
   localparam logic [1:0] SLAVE_0 = 2'd0;
   localparam logic [1:0] SLAVE_1 = 2'd1;
   localparam logic [1:0] SLAVE_2 = 2'd2;
   localparam logic [1:0] SLAVE_3 = 2'd3;
endpackage

// File: rtl/bus_serdes.sv
// bus_serdes: LSB-first shift register with parallel load, serial out/in and a shift counter.
module bus_serdes #(
   parameter int W  = 13,
   parameter int PW = 8,
   localparam int CW = $clog2(W + 1)
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          load,
   input  logic [W-1:0]  load_val,
   input  logic          shift_out,
   input  logic          shift_in,
   input  logic          din,
   output logic          dout,
   output logic [PW-1:0] pdata,
   output logic [CW-1:0] cnt
);
   logic [W-1:0] sr;
   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= load_val;
         cnt <= '0;
      end else if (shift_out | shift_in) begin
         sr  <= {shift_in & din, sr[W-1:1]};
         cnt <= cnt + 1'b1;
      end
   assign dout  = sr[0];
   // received bits enter at the top, so the assembled word sits in the upper PW bits
   assign pdata = sr[W-1 -: PW];
endmodule

// File: rtl/bus_master_port.sv
// bus_master_port: accepts one command, requests the arbiter with a serial slave select,
// then shifts address/rw, write data or read data over the shared serial bus.
module bus_master_port
   import bus_pkg::*;
#(
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int BACKOFF       = 4,
   parameter int GRANT_TIMEOUT = 32
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rw,
   input  logic [1:0]        cmd_slave,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              m_request,
   output logic              m_slave_sel,
   input  logic              m_grant,
   input  logic              arbiter_busy,
   output logic              m_dout,
   output logic              m_dout_valid,
   input  logic              m_din,
   input  logic              m_din_valid,
   input  logic              m_ack
);
   localparam int SW = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
   localparam int CW = $clog2(SW + 1);
   localparam int WW = $clog2(GRANT_TIMEOUT + 1);
   localparam int BW = $clog2(BACKOFF + 1);

   state_t state, nxt;
   logic              rw_q, seen_busy, err_q;
   logic [1:0]        slave_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [WW-1:0]     wait_cnt;
   logic [BW-1:0]     bo_cnt;
   logic              ld, sh_out, sh_in, sr_dout;
   logic [SW-1:0]     ld_val;
   logic [DATA_W-1:0] sr_pdata;
   logic [CW-1:0]     sr_cnt;
   logic              accept, decided, timeout;

   assign accept  = cmd_valid & cmd_ready;
   // a grant only counts once the arbiter has been seen busy and then released
   assign decided = seen_busy & ~arbiter_busy;
   assign timeout = wait_cnt == WW'(GRANT_TIMEOUT - 1);

   always_ff @(posedge sys_clk or posedge sys_rst)
      if (sys_rst) begin
         state     <= ST_IDLE;
         rw_q      <= 1'b0;
         slave_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         seen_busy <= 1'b0;
         err_q     <= 1'b0;
         wait_cnt  <= '0;
         bo_cnt    <= '0;
      end else begin
         state     <= nxt;
         seen_busy <= (state == ST_WAIT) & (seen_busy | arbiter_busy);
         wait_cnt  <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         bo_cnt    <= (state == ST_BACKOFF) ? bo_cnt + 1'b1 : '0;
         if (accept) begin
            rw_q    <= cmd_rw;
            slave_q <= cmd_slave;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            err_q   <= 1'b0;
         end else if (state == ST_WAIT && nxt == ST_DONE)
            err_q <= 1'b1;
      end

   always_comb begin
      nxt    = state;
      ld     = 1'b0;
      ld_val = '0;
      sh_out = 1'b0;
      sh_in  = 1'b0;
      case (state)
         ST_IDLE:    nxt = accept ? ST_SEL0 : ST_IDLE;
         ST_SEL0:    nxt = ST_SEL1;
         ST_SEL1:    nxt = ST_WAIT;
         ST_WAIT: begin
            nxt    = decided ? (m_grant ? ST_ADDR : ST_BACKOFF) : (timeout ? ST_DONE : ST_WAIT);
            ld     = decided & m_grant;
            ld_val = SW'({rw_q, addr_q});
         end
         ST_BACKOFF: nxt = (bo_cnt == BW'(BACKOFF - 1)) ? ST_SEL0 : ST_BACKOFF;
         ST_ADDR: begin
            sh_out = 1'b1;
            ld     = sr_cnt == CW'(ADDR_W);
            ld_val = rw_q ? SW'(wdata_q) : '0;
            nxt    = ld ? (rw_q ? ST_WDATA : ST_RDATA) : ST_ADDR;
         end
         ST_WDATA: begin
            sh_out = 1'b1;
            nxt    = (sr_cnt == CW'(DATA_W - 1)) ? ST_ACKW : ST_WDATA;
         end
         ST_ACKW:    nxt = m_ack ? ST_DONE : ST_ACKW;
         ST_RDATA: begin
            sh_in = m_din_valid;
            nxt   = (m_din_valid && sr_cnt == CW'(DATA_W - 1)) ? ST_DONE : ST_RDATA;
         end
         ST_DONE:    nxt = ST_IDLE;
         default:    nxt = ST_IDLE;
      endcase
   end

   bus_serdes #(.W(SW), .PW(DATA_W)) u_serdes (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .load     (ld),
      .load_val (ld_val),
      .shift_out(sh_out),
      .shift_in (sh_in),
      .din      (m_din),
      .dout     (sr_dout),
      .pdata    (sr_pdata),
      .cnt      (sr_cnt)
   );

   assign cmd_ready    = state == ST_IDLE;
   assign m_request    = state inside {ST_SEL0, ST_SEL1, ST_WAIT, ST_ADDR, ST_WDATA, ST_ACKW, ST_RDATA};
   assign m_slave_sel  = (state == ST_SEL0 & slave_q[0]) | (state == ST_SEL1 & slave_q[1]);
   assign m_dout_valid = state inside {ST_ADDR, ST_WDATA};
   assign m_dout       = m_dout_valid & sr_dout;
   assign rsp_valid    = state == ST_DONE;
   assign rsp_err      = rsp_valid & err_q;
   assign rsp_rdata    = (rsp_valid & ~rw_q & ~err_q) ? sr_pdata : '0;
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed bench with a bit/response scoreboard for bus_master_port.
module tb_bus_master_port;
   localparam int AW = 12;
   localparam int DW = 8;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_rw = 1'b0;
   logic [1:0]    cmd_slave = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          m_grant = 1'b0, arbiter_busy = 1'b0, m_din = 1'b0, m_din_valid = 1'b0, m_ack = 1'b0;
   logic          cmd_ready, rsp_valid, rsp_err, m_request, m_slave_sel, m_dout, m_dout_valid;
   logic [DW-1:0] rsp_rdata;

   int checks = 0;
   int errors = 0;
   logic          exp_bits[$];
   logic [DW:0]   exp_rsp[$];

   bus_master_port #(.ADDR_W(AW), .DATA_W(DW), .BACKOFF(4), .GRANT_TIMEOUT(32)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_slave(cmd_slave),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_request(m_request), .m_slave_sel(m_slave_sel), .m_grant(m_grant), .arbiter_busy(arbiter_busy),
      .m_dout(m_dout), .m_dout_valid(m_dout_valid), .m_din(m_din), .m_din_valid(m_din_valid), .m_ack(m_ack)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // serial-out and response monitor
   always @(negedge sys_clk) if (!sys_rst) begin
      if (m_dout_valid) begin
         if (exp_bits.size() == 0) chk("dout_extra", 1, 0);
         else chk("dout_bit", m_dout, exp_bits.pop_front());
      end else chk("dout_idle", m_dout, 0);
      if (rsp_valid) begin
         if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
         else begin
            logic [DW:0] e;
            e = exp_rsp.pop_front();
            chk("rsp_err", rsp_err, e[DW]);
            chk("rsp_rdata", rsp_rdata, e[DW-1:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic issue(input logic rw, input logic [1:0] sl, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err);
      cmd_valid = 1'b1; cmd_rw = rw; cmd_slave = sl; cmd_addr = a; cmd_wdata = wd;
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~wd; cmd_slave = ~sl;
      if (!err) begin
         for (int i = 0; i < AW; i++) exp_bits.push_back(a[i]);
         exp_bits.push_back(rw);
         if (rw) for (int i = 0; i < DW; i++) exp_bits.push_back(wd[i]);
      end
      exp_rsp.push_back({err, (rw | err) ? 8'h00 : rd});
   endtask

   task automatic sel_chk(input logic [1:0] sl);
      @(negedge sys_clk);
      chk("sel0_req", m_request, 1);
      chk("sel0_bit", m_slave_sel, sl[0]);
      @(negedge sys_clk);
      chk("sel1_bit", m_slave_sel, sl[1]);
   endtask

   // arbiter model: busy in WAIT cycles 2-3, result on cycle 4
   task automatic arb(input logic win, input logic keep);
      @(posedge sys_clk); #1 arbiter_busy = 1'b0;
      @(negedge sys_clk); chk("wait_hold1", m_dout_valid, 0);
      @(posedge sys_clk); #1 arbiter_busy = 1'b1;
      @(negedge sys_clk); chk("wait_hold2", m_dout_valid, 0);
      @(posedge sys_clk); #1;
      @(negedge sys_clk); chk("wait_hold3", {m_request, m_dout_valid}, 2'b10);
      @(posedge sys_clk); #1 arbiter_busy = 1'b0; m_grant = win;
      @(posedge sys_clk); #1 m_grant = keep;
   endtask

   task automatic wait_bits_done();
      int n;
      for (n = 0; n < 40; n++) begin
         @(negedge sys_clk);
         if (exp_bits.size() == 0 && !m_dout_valid) break;
      end
      if (n == 40) chk("bits_timeout", 0, 1);
   endtask

   task automatic wait_rsp();
      int n;
      for (n = 0; n < 40; n++) begin
         @(negedge sys_clk);
         if (rsp_valid) break;
      end
      chk("rsp_seen", rsp_valid, 1);
      @(negedge sys_clk);
      chk("ready_after", {cmd_ready, rsp_valid, m_request}, 3'b100);
   endtask

   task automatic write_done();
      wait_bits_done();
      chk("ackw_req", m_request, 1);
      @(posedge sys_clk); #1 m_ack = 1'b1;
      @(posedge sys_clk); #1 m_ack = 1'b0;
      wait_rsp();
   endtask

   initial begin
      logic [DW-1:0] rd;
      int b;
      #12;
      chk("rst_outs", {cmd_ready, rsp_valid, rsp_err, m_request, m_slave_sel, m_dout, m_dout_valid}, 7'b1000000);
      chk("rst_rdata", rsp_rdata, 0);
      @(negedge sys_clk); sys_rst = 1'b0;

      // write, no contention
      issue(1'b1, 2'd2, 12'h0A5, 8'h3C, 8'h00, 1'b0);
      sel_chk(2'd2);
      arb(1'b1, 1'b0);
      write_done();

      // read with stalled m_din_valid
      rd = 8'hA5;
      issue(1'b0, 2'd1, 12'h001, 8'h00, rd, 1'b0);
      sel_chk(2'd1);
      arb(1'b1, 1'b0);
      wait_bits_done();
      b = 0;
      for (int k = 0; k < 16; k++) begin
         @(posedge sys_clk); #1;
         if (k % 2 == 1) begin m_din_valid = 1'b1; m_din = rd[b]; b++; end
         else begin m_din_valid = 1'b0; m_din = 1'b1; end
      end
      @(posedge sys_clk); #1 m_din_valid = 1'b0; m_din = 1'b0;
      wait_rsp();

      // lost arbitration, backoff, retry; grant left high afterwards
      issue(1'b1, 2'd3, 12'h5A3, 8'hC6, 8'h00, 1'b0);
      sel_chk(2'd3);
      arb(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk); chk("backoff_req", m_request, 0);
      end
      sel_chk(2'd3);
      arb(1'b1, 1'b1);
      write_done();

      // stale grant: m_grant still 1 entering WAIT
      issue(1'b1, 2'd0, 12'hF0F, 8'h81, 8'h00, 1'b0);
      sel_chk(2'd0);
      arb(1'b1, 1'b0);
      write_done();

      // grant timeout, stray m_ack ignored
      issue(1'b0, 2'd1, 12'h123, 8'h00, 8'h00, 1'b1);
      sel_chk(2'd1);
      m_ack = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge sys_clk); chk("to_wait", {m_request, rsp_valid}, 2'b10);
      end
      @(negedge sys_clk);
      chk("to_rsp", {rsp_valid, m_request}, 2'b10);
      @(negedge sys_clk);
      chk("to_ready", cmd_ready, 1);
      m_ack = 1'b0;

      // asynchronous reset during address bit 5
      issue(1'b1, 2'd2, 12'h7E1, 8'h55, 8'h00, 1'b0);
      sel_chk(2'd2);
      arb(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin @(posedge sys_clk); #1; end
      #2 sys_rst = 1'b1;
      #1;
      chk("arst_outs", {cmd_ready, rsp_valid, m_request, m_slave_sel, m_dout, m_dout_valid}, 6'b100000);
      exp_bits.delete();
      exp_rsp.delete();
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      issue(1'b1, 2'd1, 12'h3C4, 8'hE7, 8'h00, 1'b0);
      sel_chk(2'd1);
      arb(1'b1, 1'b0);
      write_done();

      repeat (3) @(negedge sys_clk);
      chk("queues_empty", exp_bits.size() + exp_rsp.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
